mul_array: RTL and testbench

MUL_ARRAY -- requirements
Module: mul_array

---
 rtl/mul_array_pkg.sv | 29 ++
 rtl/mul_array_rle.sv | 75 +++++++
 rtl/mul_array.sv | 154 +++++++++++++++
 tb/tb_mul_array.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_array_pkg.sv
// Shared accelerator package.
// Holds the processing-element state typedefs, the default lane geometry of
// the sparse multiplier array, and the packed per-lane operand bundle.
package mul_array_pkg;

  // Processing-element control states used across the accelerator.
  typedef enum logic [1:0] {
    PE_IDLE,
    PE_LOAD,
    PE_COMPUTE,
    PE_DRAIN
  } pe_state_e;

  // Multiplier array geometry defaults.
  localparam int F_DEF    = 4;   // weight lanes per beat
  localparam int I_DEF    = 4;   // activation lanes per beat
  localparam int IDXW_DEF = 4;   // zero-run index width
  localparam int POSW_DEF = 8;   // decoded position width
  localparam int DW       = 16;  // operand width
  localparam int PW       = 32;  // product width

  // One compressed operand lane: value, zero-run length before it, valid.
  typedef struct packed {
    logic signed [DW-1:0]       data;
    logic        [IDXW_DEF-1:0] idx;
    logic                       vld;
  } lane_t;

endpackage

// File: rtl/mul_array_rle.sv
// rle_pos_decode: run-length position decoder.
// Turns per-lane zero-run indices into absolute positions using a running
// pointer that persists across accepted beats.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   adv           current beat is accepted; commit pointer / overflow state
//   clr           restart decoding from -1 with this beat
//   idx, vld      per-lane zero-run index and lane valid
//   pos           decoded absolute position per lane (0 for invalid lanes)
//   ovf           sticky wrap flag, cleared only by reset
module rle_pos_decode
  import mul_array_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IDXW  = IDXW_DEF,
  parameter int POSW  = POSW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    adv,
  input  logic                    clr,
  input  logic [LANES*IDXW-1:0]   idx,
  input  logic [LANES-1:0]        vld,
  output logic [LANES*POSW-1:0]   pos,
  output logic                    ovf
);

  logic [POSW-1:0] ptr_q, ptr_d;
  // fresh_q: pointer still sits at its -1 start value, so the first step
  // out of it carries out of POSW bits without being a real wrap.
  logic            fresh_q, fresh_d;
  logic            ovf_q, ovf_d;

  logic [POSW-1:0] p;
  logic [POSW:0]   sum;
  logic            fr;
  logic            wrap;

  always_comb begin
    p    = clr ? '1 : ptr_q;
    fr   = clr | fresh_q;
    wrap = 1'b0;
    sum  = '0;
    pos  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (vld[l]) begin
        sum = {1'b0, p} + (POSW+1)'(idx[l*IDXW +: IDXW]) + (POSW+1)'(1);
        if (sum[POSW] && !fr) begin
          wrap = 1'b1;
        end
        p  = sum[POSW-1:0];
        fr = 1'b0;
        pos[l*POSW +: POSW] = p;
      end
    end
    ptr_d   = p;
    fresh_d = fr;
    ovf_d   = ovf_q | wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '1;
      fresh_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      ptr_q   <= ptr_d;
      fresh_q <= fresh_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule

// File: rtl/mul_array.sv
// mul_array: sparse F x I outer-product multiplier with run-length position
// decode. Two pipeline stages: S1 holds operands, masks and decoded
// positions; S2 holds products. Valid/ready handshake on both sides.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid / in_ready          input beat handshake
//   act_clr, wt_clr              restart activation / weight position decode
//   act_data, act_idx, act_vld   activation lanes (I x 16 signed, I x IDXW, I)
//   wt_data, wt_idx, wt_vld      weight lanes (F x 16 signed, F x IDXW, F)
//   out_valid / out_ready        output beat handshake
//   prod, prod_vld               element [f*I+i] = wt[f]*act[i], masks ANDed
//   act_pos, wt_pos              decoded absolute positions
//   pos_ovf                      sticky position wrap flag
module mul_array
  import mul_array_pkg::*;
#(
  parameter int F    = F_DEF,
  parameter int I    = I_DEF,
  parameter int IDXW = IDXW_DEF,
  parameter int POSW = POSW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  act_clr,
  input  logic                  wt_clr,
  input  logic [I*DW-1:0]       act_data,
  input  logic [I*IDXW-1:0]     act_idx,
  input  logic [I-1:0]          act_vld,
  input  logic [F*DW-1:0]       wt_data,
  input  logic [F*IDXW-1:0]     wt_idx,
  input  logic [F-1:0]          wt_vld,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [F*I*PW-1:0]     prod,
  output logic [F*I-1:0]        prod_vld,
  output logic [I*POSW-1:0]     act_pos,
  output logic [F*POSW-1:0]     wt_pos,
  output logic                  pos_ovf
);

  logic stall;
  logic accept;

  // S1 registers
  logic                s1_valid_q;
  logic [I*DW-1:0]     act_data_q;
  logic [F*DW-1:0]     wt_data_q;
  logic [I-1:0]        act_vld_q;
  logic [F-1:0]        wt_vld_q;
  logic [I*POSW-1:0]   act_pos_s1_q;
  logic [F*POSW-1:0]   wt_pos_s1_q;

  // S2 registers
  logic                out_valid_q;
  logic [F*I*PW-1:0]   prod_q, prod_d;
  logic [F*I-1:0]      prod_vld_q, prod_vld_d;
  logic [I*POSW-1:0]   act_pos_q;
  logic [F*POSW-1:0]   wt_pos_q;

  // Decoded positions for the beat currently on the input
  logic [I*POSW-1:0]   act_pos_d;
  logic [F*POSW-1:0]   wt_pos_d;
  logic                act_ovf, wt_ovf;

  assign stall    = out_valid_q && !out_ready;
  // S1 can always refill when empty, even while S2 is stalled.
  assign in_ready = !s1_valid_q || !stall;
  assign accept   = in_valid && in_ready;

  rle_pos_decode #(.LANES(I), .IDXW(IDXW), .POSW(POSW)) u_act_dec (
    .clk (clk),
    .rst (rst),
    .adv (accept),
    .clr (act_clr),
    .idx (act_idx),
    .vld (act_vld),
    .pos (act_pos_d),
    .ovf (act_ovf)
  );

  rle_pos_decode #(.LANES(F), .IDXW(IDXW), .POSW(POSW)) u_wt_dec (
    .clk (clk),
    .rst (rst),
    .adv (accept),
    .clr (wt_clr),
    .idx (wt_idx),
    .vld (wt_vld),
    .pos (wt_pos_d),
    .ovf (wt_ovf)
  );

  // Outer product of the S1 operands; every element is computed, the mask
  // tells downstream which ones are meaningful.
  genvar gf, gi;
  generate
    for (gf = 0; gf < F; gf++) begin : g_f
      for (gi = 0; gi < I; gi++) begin : g_i
        assign prod_d[(gf*I+gi)*PW +: PW] =
          PW'($signed(wt_data_q[gf*DW +: DW])) * PW'($signed(act_data_q[gi*DW +: DW]));
        assign prod_vld_d[gf*I+gi] = wt_vld_q[gf] & act_vld_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      act_data_q   <= '0;
      wt_data_q    <= '0;
      act_vld_q    <= '0;
      wt_vld_q     <= '0;
      act_pos_s1_q <= '0;
      wt_pos_s1_q  <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        act_data_q   <= act_data;
        wt_data_q    <= wt_data;
        act_vld_q    <= act_vld;
        wt_vld_q     <= wt_vld;
        act_pos_s1_q <= act_pos_d;
        wt_pos_s1_q  <= wt_pos_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      prod_vld_q  <= '0;
      act_pos_q   <= '0;
      wt_pos_q    <= '0;
    end else if (!stall) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        prod_q     <= prod_d;
        prod_vld_q <= prod_vld_d;
        act_pos_q  <= act_pos_s1_q;
        wt_pos_q   <= wt_pos_s1_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign prod_vld  = prod_vld_q;
  assign act_pos   = act_pos_q;
  assign wt_pos    = wt_pos_q;
  assign pos_ovf   = act_ovf | wt_ovf;

endmodule

// File: tb/tb_mul_array.sv
// Directed testbench for mul_array with default geometry (F=I=4, IDXW=4,
// POSW=8). Expected values are hand-computed constants.
module tb_mul_array;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          act_clr;
  logic          wt_clr;
  logic [63:0]   act_data;
  logic [15:0]   act_idx;
  logic [3:0]    act_vld;
  logic [63:0]   wt_data;
  logic [15:0]   wt_idx;
  logic [3:0]    wt_vld;
  logic          out_valid;
  logic          out_ready;
  logic [511:0]  prod;
  logic [15:0]   prod_vld;
  logic [31:0]   act_pos;
  logic [31:0]   wt_pos;
  logic          pos_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  mul_array dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act_clr   (act_clr),
    .wt_clr    (wt_clr),
    .act_data  (act_data),
    .act_idx   (act_idx),
    .act_vld   (act_vld),
    .wt_data   (wt_data),
    .wt_idx    (wt_idx),
    .wt_vld    (wt_vld),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .prod_vld  (prod_vld),
    .act_pos   (act_pos),
    .wt_pos    (wt_pos),
    .pos_ovf   (pos_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pr(input int k);
    return prod[k*32 +: 32];
  endfunction

  int or_tab[12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  int ir_tab[12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  int ov_tab[12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int q[$];
  int tag;
  int popped;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    act_clr = 1'b0; wt_clr = 1'b0;
    act_data = '0; act_idx = '0; act_vld = '0;
    wt_data = '0; wt_idx = '0; wt_vld = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_act_pos",   64'(act_pos),   64'(0));
    chk("rst_wt_pos",    64'(wt_pos),    64'(0));
    chk("rst_prod_vld",  64'(prod_vld),  64'(0));
    chk("rst_pos_ovf",   64'(pos_ovf),   64'(0));
    chk("rst_prod0",     64'(pr(0)),     64'(0));
    $display("reset checked");

    // Beat 1: clear, idx {0,2,0,1}, all valid, signed extremes
    in_valid = 1'b1;
    act_clr  = 1'b1; act_idx = 16'h1020; act_vld = 4'hF;
    act_data = {16'h8000, 16'h0001, 16'hFFFB, 16'h0004};
    wt_clr   = 1'b1; wt_idx = 16'h0000; wt_vld = 4'hF;
    wt_data  = {16'h7FFF, 16'h0000, 16'h0002, 16'hFFFD};
    tick();
    chk("lat_1cycle_out_valid", 64'(out_valid), 64'(0));
    $display("beat1 accepted");

    // Beat 2: continue, idx {1,0,0,0}, vld {1,0,1,1}
    act_clr  = 1'b0; act_idx = 16'h0001; act_vld = 4'b1101;
    act_data = {16'h0000, 16'h0007, 16'hFFFF, 16'h0064};
    wt_clr   = 1'b0; wt_idx = 16'h0000; wt_vld = 4'hF;
    wt_data  = {16'hFFD8, 16'h001E, 16'hFFEC, 16'h000A};
    tick();
    chk("b1_out_valid", 64'(out_valid), 64'(1));
    chk("b1_act_pos",   64'(act_pos),   64'(32'h06040300));
    chk("b1_wt_pos",    64'(wt_pos),    64'(32'h03020100));
    chk("b1_prod_vld",  64'(prod_vld),  64'(16'hFFFF));
    chk("b1_prod0",     64'(pr(0)),     64'(32'hFFFFFFF4));
    chk("b1_prod1",     64'(pr(1)),     64'(32'h0000000F));
    chk("b1_prod12",    64'(pr(12)),    64'(32'h0001FFFC));
    chk("b1_prod15",    64'(pr(15)),    64'(32'hC0008000));
    $display("beat1 output checked");

    in_valid = 1'b0;
    tick();
    chk("b2_out_valid", 64'(out_valid), 64'(1));
    chk("b2_act_pos",   64'(act_pos),   64'(32'h0A090008));
    chk("b2_wt_pos",    64'(wt_pos),    64'(32'h07060504));
    chk("b2_prod_vld",  64'(prod_vld),  64'(16'hDDDD));
    chk("b2_prod5",     64'(pr(5)),     64'(32'h00000014));
    chk("b2_prod10",    64'(pr(10)),    64'(32'h000000D2));
    $display("beat2 output checked");

    tick();
    chk("bubble_out_valid", 64'(out_valid), 64'(0));

    // Back-to-back beats with a 3-cycle downstream stall
    act_clr = 1'b1; act_idx = '0; act_vld = 4'hF;
    wt_clr  = 1'b1; wt_idx = '0; wt_vld = 4'hF;
    wt_data = {48'd0, 16'h0001};
    tag = 1;
    popped = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = or_tab[c][0];
      in_valid  = (tag <= 5);
      act_data  = {48'd0, 16'(tag)};
      #1;
      chk($sformatf("stall_in_ready_c%0d", c), 64'(in_ready), 64'(ir_tab[c]));
      chk($sformatf("stall_out_valid_c%0d", c), 64'(out_valid), 64'(ov_tab[c]));
      if (out_valid) begin
        chk($sformatf("stall_prod0_c%0d", c), 64'(pr(0)),
            64'((q.size() > 0) ? q[0] : 32'hDEAD));
        if (out_ready && q.size() > 0) begin
          void'(q.pop_front());
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(tag);
        tag++;
      end
      $display("stall cycle %0d in_ready=%0d out_valid=%0d prod0=%0d", c, in_ready, out_valid, pr(0));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_popped", 64'(popped), 64'(5));
    chk("stall_queue_left", 64'(q.size()), 64'(0));

    // Drive the activation pointer to 250, then wrap it
    wt_vld = 4'h0; wt_clr = 1'b0;
    act_data = {16'd4, 16'd3, 16'd2, 16'd1};
    in_valid = 1'b1;
    act_clr = 1'b1; act_idx = 16'hEFFF; act_vld = 4'hF;
    tick();
    act_clr = 1'b0; act_idx = 16'hFFFF;
    tick();
    tick();
    act_idx = 16'hBFFF;
    tick();
    chk("ovf_before_wrap", 64'(pos_ovf), 64'(0));
    act_idx = 16'h000F; act_vld = 4'b0001;
    tick();
    chk("ovf_after_wrap", 64'(pos_ovf), 64'(1));
    chk("pos_250_act_pos", 64'(act_pos), 64'(32'hFAEEDECE));
    act_vld = 4'h0; wt_clr = 1'b1; wt_vld = 4'hF; wt_idx = '0;
    tick();
    chk("wrap_act_pos", 64'(act_pos), 64'(32'h0000000A));
    in_valid = 1'b0; wt_clr = 1'b0;
    tick();
    chk("ovf_after_wt_clr", 64'(pos_ovf), 64'(1));
    rst = 1'b1;
    tick();
    chk("ovf_after_rst", 64'(pos_ovf), 64'(0));
    rst = 1'b0;
    $display("position wrap checked");

    // Reset with two beats in flight
    in_valid = 1'b1;
    act_clr = 1'b1; act_idx = '0; act_vld = 4'hF;
    wt_clr = 1'b1; wt_idx = '0; wt_vld = 4'hF;
    tick();
    act_clr = 1'b0; wt_clr = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    act_clr = 1'b0; act_idx = 16'h0002; act_vld = 4'hF;
    wt_clr = 1'b0; wt_idx = '0; wt_vld = 4'hF;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midrst_y_out_valid", 64'(out_valid), 64'(1));
    chk("midrst_y_act_pos",   64'(act_pos),   64'(32'h05040302));
    chk("midrst_y_wt_pos",    64'(wt_pos),    64'(32'h03020100));
    $display("mid-stream reset checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
